// File: rtl/data_path_pkg.sv
// Shared data path definitions: block width and
// serializer transmit states.
package data_path_pkg;

  localparam int DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up counter with synchronous clear and a
// programmable rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [WIDTH-1:0] rollover_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      if (count_q == rollover_i)
        count_d = '0;
      else
        count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/data_serializer.sv
// MSB-first parallel-to-serial transmitter with a
// fixed clocks-per-bit rate and registered outputs.
module data_serializer
  import data_path_pkg::*;
#(
  parameter int DATA_WIDTH   = data_path_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_data,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  bit_strobe,
  output logic                  tx_done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_CAP =
    BIT_W'(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  accept, bit_end, in_shift;

  logic ready_q, ready_d;
  logic sout_q, sout_d;
  logic valid_q, valid_d;
  logic strb_q, strb_d;
  logic done_q, done_d;

  assign in_shift = (state_q == SHIFT);
  assign accept   = load_data && ready_q;
  assign bit_end  = in_shift && (div_cnt == DIV_MAX);

  flex_counter #(.WIDTH(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .count_en_i (in_shift),
    .rollover_i (DIV_MAX),
    .count_o    (div_cnt)
  );

  // Rollover set past the last bit so the count never wraps mid-frame.
  flex_counter #(.WIDTH(BIT_W)) u_bit (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .count_en_i (bit_end),
    .rollover_i (BIT_CAP),
    .count_o    (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_cnt == BIT_LAST)
            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    sout_d  = 1'b1;
    valid_d = 1'b0;
    strb_d  = 1'b0;
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
    if (state_d == SHIFT) begin
      sout_d  = shift_d[DATA_WIDTH-1];
      valid_d = 1'b1;
      strb_d  = accept || bit_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      ready_q <= 1'b1;
      sout_q  <= 1'b1;
      valid_q <= 1'b0;
      strb_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
    end
  end

  assign load_ready   = ready_q;
  assign serial_out   = sout_q;
  assign serial_valid = valid_q;
  assign bit_strobe   = strb_q;
  assign tx_done      = done_q;

endmodule

// File: tb/tb_data_serializer.sv
// Randomized bench for data_serializer against a
// frame-level model; covers default and 2-clock rates.
module tb_data_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   ld  = 2'b00;
  logic [127:0] din = '0;
  logic [1:0]   so, sv, bs, td, lr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_serializer #(
    .DATA_WIDTH   (128),
    .CLKS_PER_BIT (4)
  ) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .load_data    (ld[0]),
    .data_in      (din),
    .load_ready   (lr[0]),
    .serial_out   (so[0]),
    .serial_valid (sv[0]),
    .bit_strobe   (bs[0]),
    .tx_done      (td[0])
  );

  data_serializer #(
    .DATA_WIDTH   (128),
    .CLKS_PER_BIT (2)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .load_data    (ld[1]),
    .data_in      (din),
    .load_ready   (lr[1]),
    .serial_out   (so[1]),
    .serial_valid (sv[1]),
    .bit_strobe   (bs[1]),
    .tx_done      (td[1])
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] stat(input int s);
    return {sv[s], bs[s], td[s], lr[s]};
  endfunction

  task automatic start(input int s,
                       input logic [127:0] d);
    for (int i = 0; i < 600 && !lr[s]; i++)
      @(negedge clk);
    chk("ready", lr[s], 1);
    din   = d;
    ld[s] = 1'b1;
    @(posedge clk);
    #1 ld[s] = 1'b0;
  endtask

  // Frame model: cycle c after the load edge carries bit (c-1)/cpb.
  task automatic run_frame(input int s,
                           input logic [127:0] d,
                           input int busy_at,
                           output int low);
    int cpb;
    int n;
    int nstr;
    logic [127:0] cap;
    logic eo;
    logic [3:0] es;
    cpb  = (s == 1) ? 2 : 4;
    n    = 128 * cpb;
    nstr = 0;
    cap  = '0;
    low  = 0;
    start(s, d);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c <= n) begin
        eo = d[127 - (c - 1) / cpb];
        es = {1'b1, ((c - 1) % cpb) == 0, 2'b00};
      end else if (c == n + 1) begin
        eo = 1'b1;
        es = 4'b0010;
      end else begin
        eo = 1'b1;
        es = 4'b0001;
      end
      chk("sout", so[s], eo);
      chk("stat", stat(s), es);
      if (bs[s]) begin
        cap = {cap[126:0], so[s]};
        nstr++;
      end
      if (!sv[s]) low++;
      ld[s] = 1'b0;
      if (c == busy_at) begin
        din   = 128'd74;
        ld[s] = 1'b1;
      end
    end
    chk("word", cap, d);
    chk("nstrb", nstr, 128);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int low;
    logic [127:0] ones;
    logic [127:0] pa;
    logic [127:0] pb;
    ones = '1;
    pa   = {16{8'hAA}};
    pb   = {16{8'h55}};

    #2 rst = 1'b1;
    #1;
    chk("rst_sout", so, 2'b11);
    chk("rst_vld", sv, 2'b00);
    chk("rst_strb", bs, 2'b00);
    chk("rst_done", td, 2'b00);
    chk("rst_rdy", lr, 2'b11);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, 128'd69, 0, low);
    chk("gap69", low, 2);
    run_frame(0, 128'd69, 37, low);
    run_frame(0, pa, 0, low);
    run_frame(0, pb, 0, low);
    chk("gap_b2b", low, 2);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame($urandom_range(0, 1), rnd128(),
                $urandom_range(1, 200), low);
    end

    start(0, rnd128());
    repeat (160) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abrt_sout", so[0], 1);
    chk("abrt_stat", stat(0), 4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abrt_done", td[0], 0);
    end
    rst = 1'b0;
    run_frame(0, ones, 0, low);

    run_frame(1, ones, 0, low);
    run_frame(1, 128'd69, 100, low);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
